player_move_ctrl: RTL

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

---
 rtl/wolf_pkg.sv | 57 +++++
 rtl/frame_tick_gen.sv | 34 +++
 rtl/player_move_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wolf_pkg.sv
// Shared types and constants for the player movement logic.
// Direction/state encodings plus saturating position helpers.
package wolf_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_REQ,
    S_WAIT,
    S_APPLY
  } state_t;

  localparam int X_RESET_DEF = 310;
  localparam int Y_RESET_DEF = 220;
  localparam int X_MAX_DEF   = 620;
  localparam int Y_MAX_DEF   = 460;

  // Opposing buttons cancel out to no motion on that axis.
  function automatic dir_t axis_dir(
    input logic pos,
    input logic neg
  );
    dir_t d;
    d = DIR_NONE;
    if (pos && !neg) d = DIR_POS;
    if (neg && !pos) d = DIR_NEG;
    return d;
  endfunction

  // 11-bit saturating step, clamped to [0, max].
  function automatic logic [9:0] step_pos(
    input logic [9:0] p,
    input dir_t       d,
    input int         step,
    input int         max
  );
    logic [10:0] w;
    logic [10:0] s;
    logic [10:0] m;
    w = {1'b0, p};
    s = 11'(step);
    m = 11'(max);
    unique case (d)
      DIR_POS: w = (w + s > m) ? m : w + s;
      DIR_NEG: w = (w < s) ? 11'd0 : w - s;
      default: w = w;
    endcase
    return w[9:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// vsync falling-edge detector plus frame divider.
// tick fires on the edge that wraps the divider to zero.
module frame_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  localparam logic [3:0] DIV_M1 = 4'(TICK_DIV - 1);

  logic       vs_q;
  logic [3:0] cnt;
  logic       fe;
  logic       wrap;

  assign fe   = vs_q & ~vsync;
  assign wrap = (cnt == DIV_M1);
  assign tick = fe & wrap;

  // Delayed vsync copy and edge counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_q <= 1'b1;
      cnt  <= 4'd0;
    end else begin
      vs_q <= vsync;
      if (fe) cnt <= wrap ? 4'd0 : cnt + 4'd1;
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player position controller: samples buttons once per tick,
// asks the limiter whether the move is legal, then applies it.
module player_move_ctrl
  import wolf_pkg::*;
#(
  parameter int X_RESET     = X_RESET_DEF,
  parameter int Y_RESET     = Y_RESET_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int STEP        = 1,
  parameter int TICK_DIV    = 1,
  parameter int LIM_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  output logic       lim_start,
  input  logic       lim_done,
  input  logic       lim_valid,
  output logic [1:0] lim_l_r,
  output logic [1:0] lim_u_d,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       busy,
  output logic       timeout_err
);

  localparam int WW = $clog2(LIM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO_M1 = WW'(LIM_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          tick;
  dir_t          lr_q;
  dir_t          ud_q;
  dir_t          lr_in;
  dir_t          ud_in;
  logic          valid_q;
  logic [WW-1:0] wait_cnt;

  logic do_sample;
  logic do_req;
  logic do_done;
  logic do_abort;
  logic do_apply;
  logic wait_inc;

  frame_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .vsync(vsync),
    .tick (tick)
  );

  assign lr_in   = axis_dir(right, left);
  assign ud_in   = axis_dir(down, up);
  assign lim_l_r = lr_q;
  assign lim_u_d = ud_q;
  assign busy    = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and per-state strobes; done beats timeout.
  always_comb begin
    state_nxt = state;
    do_sample = 1'b0;
    do_req    = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    do_apply  = 1'b0;
    wait_inc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        do_sample = 1'b1;
        if (lr_in == DIR_NONE && ud_in == DIR_NONE)
          state_nxt = S_IDLE;
        else
          state_nxt = S_REQ;
      end
      S_REQ: begin
        do_req    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lim_done) begin
          do_done   = 1'b1;
          state_nxt = S_APPLY;
        end else if (wait_cnt == TO_M1) begin
          do_abort  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wait_inc  = 1'b1;
        end
      end
      S_APPLY: begin
        do_apply  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: directions, handshake, watchdog and position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lr_q        <= DIR_NONE;
      ud_q        <= DIR_NONE;
      lim_start   <= 1'b0;
      valid_q     <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      x           <= 10'(X_RESET);
      y           <= 10'(Y_RESET);
    end else begin
      if (do_sample) begin
        lr_q <= lr_in;
        ud_q <= ud_in;
      end
      if (do_req) begin
        lim_start <= 1'b1;
        wait_cnt  <= '0;
      end
      if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
      if (do_done) begin
        lim_start <= 1'b0;
        valid_q   <= lim_valid;
      end
      if (do_abort) begin
        lim_start   <= 1'b0;
        timeout_err <= 1'b1;
      end
      if (do_apply && valid_q) begin
        x <= step_pos(x, lr_q, STEP, X_MAX);
        y <= step_pos(y, ud_q, STEP, Y_MAX);
      end
    end
  end

endmodule
